// File: rtl/ddr2ibuf_dispatch.sv
// ddr2ibuf_dispatch
// Unpacks a DDR index stream into 2*IDX_W-bit entries and writes them into
// the per-PE index buffers, either broadcasting one list to every enabled PE
// or scattering consecutive segments to the enabled PEs in ascending order.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start / done    one-cycle start pulse (honoured only when idle) / idle flag
//   conf_mode       [0] scatter(1)/broadcast(0); [2:1]==2'b01 swaps entry halves
//   conf_idx_num    entries per PE (0..IDX_DEPTH)
//   conf_mask       enabled PEs
//   ddr_data/valid  DDR stream word and its valid; ddr_ready accepts it
//   idx_wr_*        registered write port towards the PE index buffers
module ddr2ibuf_dispatch #(
  parameter int DDR_W     = 512,
  parameter int IDX_W     = 16,
  parameter int PE_NUM    = 32,
  parameter int IDX_DEPTH = 256,
  parameter int ADDR_W    = $clog2(IDX_DEPTH),
  parameter int IDX_BATCH = DDR_W / (2 * IDX_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 done,
  input  logic [3:0]           conf_mode,
  input  logic [ADDR_W:0]      conf_idx_num,
  input  logic [PE_NUM-1:0]    conf_mask,
  input  logic [DDR_W-1:0]     ddr_data,
  input  logic                 ddr_valid,
  output logic                 ddr_ready,
  output logic [2*IDX_W-1:0]   idx_wr_data,
  output logic [ADDR_W-1:0]    idx_wr_addr,
  output logic [PE_NUM-1:0]    idx_wr_en
);

  localparam int EW    = 2 * IDX_W;
  localparam int KW    = (IDX_BATCH > 1) ? $clog2(IDX_BATCH) : 1;
  localparam int PE_W  = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
  localparam int CNT_W = ADDR_W + 1 + PE_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, UNPACK, FLUSH} state_t;

  state_t state_q, state_d;

  logic              scatter_r, swap_r;
  logic [ADDR_W:0]   num_r;
  logic [PE_NUM-1:0] mask_r;

  logic [DDR_W-1:0]  word_p0;
  logic [KW-1:0]     k_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [PE_W-1:0]   pe_p0;
  logic [CNT_W-1:0]  left_p0;

  logic [EW-1:0]     wr_data_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [PE_NUM-1:0] wr_en_p1;

  function automatic logic [PE_W:0] popcount(input logic [PE_NUM-1:0] m);
    logic [PE_W:0] c;
    c = '0;
    for (int i = 0; i < PE_NUM; i++) c = c + {{PE_W{1'b0}}, m[i]};
    return c;
  endfunction

  // Downward scan so the lowest qualifying index wins.
  function automatic logic [PE_W-1:0] first_pe(input logic [PE_NUM-1:0] m);
    logic [PE_W-1:0] r;
    r = '0;
    for (int i = PE_NUM - 1; i >= 0; i--) if (m[i]) r = PE_W'(i);
    return r;
  endfunction

  function automatic logic [PE_W-1:0] next_pe(input logic [PE_NUM-1:0] m,
                                              input logic [PE_W-1:0]   cur);
    logic [PE_W-1:0] r;
    r = '0;
    for (int i = PE_NUM - 1; i >= 0; i--) if (m[i] && (i > int'(cur))) r = PE_W'(i);
    return r;
  endfunction

  function automatic logic [EW-1:0] swap_halves(input logic [EW-1:0] e, input logic sw);
    return sw ? {e[IDX_W-1:0], e[EW-1:IDX_W]} : e;
  endfunction

  logic [EW-1:0]    entry_sel;
  logic             last_k, last_ent, seg_end, hs;
  logic [CNT_W-1:0] total_start;

  assign entry_sel   = word_p0[int'(k_p0)*EW +: EW];
  assign last_k      = (k_p0 == KW'(IDX_BATCH - 1));
  assign last_ent    = (left_p0 == CNT_W'(1));
  assign seg_end     = ({1'b0, addr_p0} == (num_r - (ADDR_W+1)'(1)));
  assign total_start = conf_mode[0] ? CNT_W'(conf_idx_num) * CNT_W'(popcount(conf_mask))
                                    : CNT_W'(conf_idx_num);
  assign hs          = ddr_valid && ddr_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ddr_ready decodes registered state only; ddr_valid steers just the next state.
  always_comb begin
    state_d   = state_q;
    ddr_ready = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        done = 1'b1;
        if (start) state_d = (total_start == '0) ? FLUSH : FETCH;
      end
      FETCH: begin
        ddr_ready = 1'b1;
        if (ddr_valid) state_d = UNPACK;
      end
      UNPACK: begin
        if (last_ent) begin
          state_d = FLUSH;
        end else if (last_k) begin
          ddr_ready = 1'b1;
          state_d   = ddr_valid ? UNPACK : FETCH;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: configuration latch, word register and entry/PE/address counters
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      scatter_r <= conf_mode[0];
      swap_r    <= (conf_mode[2:1] == 2'b01);
      num_r     <= conf_idx_num;
      mask_r    <= conf_mask;
      left_p0   <= total_start;
      addr_p0   <= '0;
      pe_p0     <= first_pe(conf_mask);
    end
    if (hs) begin
      word_p0 <= ddr_data;
      k_p0    <= '0;
    end else if (state_q == UNPACK) begin
      k_p0 <= k_p0 + KW'(1);
    end
    if (state_q == UNPACK) begin
      left_p0 <= left_p0 - CNT_W'(1);
      if (seg_end) begin
        addr_p0 <= '0;
        if (scatter_r) pe_p0 <= next_pe(mask_r, pe_p0);
      end else begin
        addr_p0 <= addr_p0 + ADDR_W'(1);
      end
    end
  end

  // Stage p1: registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_p1   <= '0;
      wr_data_p1 <= '0;
      wr_addr_p1 <= '0;
    end else begin
      wr_en_p1 <= '0;
      if (state_q == UNPACK) begin
        wr_en_p1   <= scatter_r ? (PE_NUM'(1) << pe_p0) : mask_r;
        wr_data_p1 <= swap_halves(entry_sel, swap_r);
        wr_addr_p1 <= addr_p0;
      end
    end
  end

  assign idx_wr_data = wr_data_p1;
  assign idx_wr_addr = wr_addr_p1;
  assign idx_wr_en   = wr_en_p1;

endmodule
